// File: rtl/shreg_pkg.sv
// Shared encodings for the universal shift register: step modes, shift direction and FSM states.
package shreg_pkg;

    localparam logic [1:0] MODE_SHIFT = 2'b00;
    localparam logic [1:0] MODE_ROT   = 2'b01;
    localparam logic [1:0] MODE_LOAD  = 2'b10;
    localparam logic [1:0] MODE_ASH   = 2'b11;

    localparam logic DIR_RIGHT = 1'b1;
    localparam logic DIR_LEFT  = 1'b0;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Step configuration latched at START and held for the whole run.
    typedef struct packed {
        logic [1:0] mode;
        logic       dir;
    } step_cfg_t;

endpackage

// File: rtl/shreg_step.sv
// One-position step of the universal shift register (purely combinational).
// The legacy single-step path and the multi-step RUN path both use it.
module shreg_step
    import shreg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [1:0]       modo,
    input  logic             dir,
    input  logic             s_in,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q_nxt,
    output logic             ej
);

    logic fill;

    always_comb begin
        ej   = (dir == DIR_RIGHT) ? q[0] : q[WIDTH-1];
        fill = s_in;
        case (modo)
            MODE_SHIFT: fill = s_in;
            MODE_ROT:   fill = ej;
            MODE_ASH:   fill = (dir == DIR_RIGHT) ? q[WIDTH-1] : 1'b0;
            default:    fill = s_in;
        endcase

        if (modo == MODE_LOAD)
            q_nxt = d;
        else if (dir == DIR_RIGHT)
            q_nxt = {fill, q[WIDTH-1:1]};
        else
            q_nxt = {q[WIDTH-2:0], fill};
    end

endmodule

// File: rtl/univ_shift_reg_n.sv
// WIDTH-bit universal shift register: legacy single steps plus a START/AMT
// multi-step command with BUSY/DONE handshake. All outputs are registered.
module univ_shift_reg_n
    import shreg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ENB,
    input  logic             DIR,
    input  logic             S_IN,
    input  logic [1:0]       MODO,
    input  logic [WIDTH-1:0] D,
    input  logic             START,
    input  logic [CNT_W-1:0] AMT,
    output logic [WIDTH-1:0] Q,
    output logic             S_OUT,
    output logic             BUSY,
    output logic             DONE
);

    logic [0:0]       st;
    logic [CNT_W-1:0] cnt;
    step_cfg_t        cfg;
    step_cfg_t        cfg_eff;
    logic [WIDTH-1:0] q_nxt;
    logic             ej;

    // In RUN the step uses the configuration latched at START, not the live pins.
    assign cfg_eff = (st == ST_RUN) ? cfg : step_cfg_t'{mode: MODO, dir: DIR};

    shreg_step #(.WIDTH(WIDTH)) u_step (
        .q     (Q),
        .modo  (cfg_eff.mode),
        .dir   (cfg_eff.dir),
        .s_in  (S_IN),
        .d     (D),
        .q_nxt (q_nxt),
        .ej    (ej)
    );

    assign BUSY = (st == ST_RUN);

    always_ff @(posedge CLK) begin
        if (RST) begin
            st    <= ST_IDLE;
            cnt   <= '0;
            cfg   <= '0;
            Q     <= '0;
            S_OUT <= 1'b0;
            DONE  <= 1'b0;
        end else if (ENB) begin
            DONE <= 1'b0;
            case (st)
                ST_IDLE: begin
                    if (START) begin
                        if (MODO == MODE_LOAD) begin
                            Q    <= D;
                            DONE <= 1'b1;
                        end else if (AMT == '0) begin
                            DONE <= 1'b1;
                        end else begin
                            cfg <= step_cfg_t'{mode: MODO, dir: DIR};
                            cnt <= AMT;
                            st  <= ST_RUN;
                        end
                    end else begin
                        Q <= q_nxt;
                        if (MODO != MODE_LOAD)
                            S_OUT <= ej;
                    end
                end
                default: begin
                    Q     <= q_nxt;
                    S_OUT <= ej;
                    cnt   <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        st   <= ST_IDLE;
                        DONE <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_univ_shift_reg_n.sv
// Randomised and directed check of univ_shift_reg_n (WIDTH=4) against a behavioural model.
module tb_univ_shift_reg_n;

    localparam int W     = 4;
    localparam int CW    = $clog2(W + 1);
    localparam int MASK  = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          rst, enb, dir, s_in, start;
    logic [1:0]    modo;
    logic [W-1:0]  d;
    logic [CW-1:0] amt;
    logic [W-1:0]  q;
    logic          s_out, busy, done;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state.
    int m_q, m_s, m_busy, m_done, m_rem, m_mode, m_dir;

    always #5 clk = ~clk;

    univ_shift_reg_n #(.WIDTH(W)) dut (
        .CLK(clk), .RST(rst), .ENB(enb), .DIR(dir), .S_IN(s_in), .MODO(modo),
        .D(d), .START(start), .AMT(amt), .Q(q), .S_OUT(s_out), .BUSY(busy), .DONE(done)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // One position of movement, written as integer arithmetic on the value.
    task automatic do_step(input int mode, input int dr, input int sin, inout int val, output int ejb);
        int fill;
        if (dr == 1) begin
            ejb  = val % 2;
            fill = (mode == 0) ? sin : (mode == 1) ? ejb : (val >= (1 << (W - 1)));
            val  = val / 2 + fill * (1 << (W - 1));
        end else begin
            ejb  = (val >= (1 << (W - 1)));
            fill = (mode == 0) ? sin : (mode == 1) ? ejb : 0;
            val  = (val * 2 + fill) % (1 << W);
        end
    endtask

    task automatic model_edge();
        int e;
        if (rst) begin
            m_q = 0; m_s = 0; m_busy = 0; m_done = 0; m_rem = 0;
        end else if (enb) begin
            m_done = 0;
            if (m_busy) begin
                do_step(m_mode, m_dir, int'(s_in), m_q, e);
                m_s = e;
                m_rem--;
                if (m_rem == 0) begin m_busy = 0; m_done = 1; end
            end else if (start) begin
                if (modo == 2'b10) begin m_q = int'(d); m_done = 1; end
                else if (amt == 0) m_done = 1;
                else begin
                    m_mode = int'(modo); m_dir = int'(dir); m_rem = int'(amt); m_busy = 1;
                end
            end else if (modo == 2'b10) begin
                m_q = int'(d);
            end else begin
                do_step(int'(modo), int'(dir), int'(s_in), m_q, e);
                m_s = e;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("q", int'(q), m_q & MASK);
        chk("s_out", int'(s_out), m_s);
        chk("busy", int'(busy), m_busy);
        chk("done", int'(done), m_done);
    endtask

    task automatic load(input int v);
        start = 0; modo = 2'b10; d = W'(v); tick();
    endtask

    task automatic go(input int mode, input int dr, input int n);
        start = 1; modo = 2'(mode); dir = dr[0]; amt = CW'(n); tick();
        start = 0;
    endtask

    int exp_q[4];
    int exp_s[4];

    initial begin
        m_q = 0; m_s = 0; m_busy = 0; m_done = 0; m_rem = 0; m_mode = 0; m_dir = 0;
        rst = 1; enb = 1'($urandom); dir = 1'($urandom); s_in = 1'($urandom);
        start = 1'($urandom); modo = 2'($urandom); d = W'($urandom); amt = CW'($urandom);
        tick(); tick();
        chk("rst_q", int'(q), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        rst = 0; enb = 1; s_in = 0;

        // Legacy rotate right of 0001.
        load(1);
        exp_q = '{8, 4, 2, 1};
        exp_s = '{1, 0, 0, 0};
        modo = 2'b01; dir = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rot_q", int'(q), exp_q[i]);
            chk("rot_s", int'(s_out), exp_s[i]);
        end

        // Multi-step serial left with S_IN=1.
        load(11);
        s_in = 1;
        go(0, 0, 2);
        tick(); chk("ser_q1", int'(q), 7);  chk("ser_s1", int'(s_out), 1);
        tick(); chk("ser_q2", int'(q), 15); chk("ser_s2", int'(s_out), 0);
        chk("ser_done", int'(done), 1);
        s_in = 0;

        // Arithmetic right, then a back-to-back START on the DONE cycle.
        load(8);
        go(3, 1, 3);
        tick(); chk("ash_q1", int'(q), 12);
        tick(); chk("ash_q2", int'(q), 14);
        tick(); chk("ash_q3", int'(q), 15);
        chk("ash_done", int'(done), 1);
        go(1, 1, 1);
        chk("b2b_busy", int'(busy), 1);
        tick();

        // ENB pause mid-run and a START while busy.
        load(9);
        go(1, 0, 4);
        tick(); tick();
        enb = 0; tick(); tick();
        enb = 1; start = 1; modo = 2'b10; amt = 1; tick();
        start = 0; tick();
        chk("pause_done", int'(done), 1);

        // Reset mid-run aborts with no DONE.
        load(6);
        go(1, 1, 4);
        tick(); tick();
        rst = 1; tick();
        chk("abort_q", int'(q), 0);
        chk("abort_busy", int'(busy), 0);
        rst = 0; tick();
        chk("abort_done", int'(done), 0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            rst   = ($urandom_range(0, 49) == 0);
            enb   = ($urandom_range(0, 99) < 85);
            dir   = 1'($urandom);
            s_in  = 1'($urandom);
            modo  = 2'($urandom);
            d     = W'($urandom);
            start = ($urandom_range(0, 99) < 25);
            amt   = CW'($urandom_range(0, 7));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg_n.md
# univ_shift_reg_n

Parametrised universal shift register: the next generation of the team's 4-bit shift/rotate register, generalised to WIDTH bits. It adds an arithmetic-shift mode and a multi-step command, where one START shifts AMT positions at one position per clock with a BUSY/DONE handshake. Single-step behaviour is unchanged, so existing Test-style benches still apply. It sits between the stimulus/control logic and any downstream serial consumer, which reads S_OUT.

## Interface
- WIDTH, 8: register width in bits (≥2).
- CNT_W, $clog2(WIDTH+1): width of AMT and the internal step counter.
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, synchronous and active-high; overrides every other input.
- ENB  in  1  global enable; 0 freezes all state (Q, S_OUT, counter, FSM).
- DIR  in  1  1 = right (toward LSB), 0 = left.
- S_IN  in  1  serial input bit for MODO=00.
- MODO  in  2  00 serial shift, 01 rotate, 10 parallel load, 11 arithmetic shift.
- D  in  WIDTH  parallel load data.
- START  in  1  request a multi-step operation; sampled only in IDLE with ENB=1.
- AMT  in  CNT_W  number of steps for START; valid range 0..WIDTH.
- Q  out  WIDTH  register contents.
- S_OUT  out  1  registered copy of the bit shifted out by the most recent shift or rotate step.
- BUSY  out  1  high while a multi-step operation is in RUN.
- DONE  out  1  one-cycle pulse when a START operation completes.

## Operation
- Step function, one position per step:
  - 00: vacated bit = S_IN.
  - 01: vacated bit = ejected bit (wrap-around).
  - 11 right: vacated MSB = old MSB (sign fill).
  - 11 left: vacated LSB = 0.
  - 10: Q ← D; S_OUT is unchanged.
- S_OUT ← ejected bit: Q[0] when shifting right, Q[WIDTH-1] when shifting left.
- FSM states are IDLE and RUN.
- In IDLE with ENB=1 and START=0, one step per clock using the live MODO and DIR (legacy mode).
- In IDLE with ENB=1 and START=1:
  - MODO=10: load D; DONE is asserted next cycle; stay in IDLE.
  - AMT=0: Q unchanged; DONE is asserted next cycle; stay in IDLE.
  - Otherwise: latch MODO and DIR; counter ← AMT; no step on this edge; go to RUN.
- In RUN with ENB=1:
  - Perform one step using the latched MODO and DIR. S_IN is sampled live each cycle.
  - Decrement the counter. When the counter goes 1→0, return to IDLE and assert DONE for one cycle.
- In RUN with ENB=0: everything holds, and DONE is delayed accordingly.
- START, MODO, DIR and D are ignored in RUN; START while BUSY is dropped, not queued.
- Back-to-back operation: a START on the DONE cycle (IDLE) is accepted.
- AMT > WIDTH is out of contract; the implementation must still terminate after AMT steps, with no clamping.

## Timing
- Reset values: Q=0, S_OUT=0, BUSY=0, DONE=0, FSM=IDLE, counter=0. RST during RUN aborts with no DONE.
- START accepted at edge k with AMT=N>0:
  - BUSY is high from after edge k until edge k+N.
  - Shifts occur on edges k+1..k+N.
  - DONE is high for the one cycle after edge k+N, coincident with the final Q.
  - Latency from START to DONE is N+1 cycles with ENB held at 1.
- Legacy step, load and zero-AMT START: result is visible after a single edge.
- All outputs are registered; there is no combinational input→output path.

## Structure
- Package shreg_pkg holds:
  - MODE_SHIFT=2'b00, MODE_ROT=2'b01, MODE_LOAD=2'b10, MODE_ASH=2'b11;
  - DIR_RIGHT=1'b1, DIR_LEFT=1'b0;
  - state encodings ST_IDLE and ST_RUN.
- Sub-module shreg_step is purely combinational: it takes (Q, MODO, DIR, S_IN, D) and produces (next Q, ejected bit). It is shared by the legacy and RUN paths.
- The top level contains only the FSM, the counter, the latches and the output registers.

## Test plan
All scenarios use WIDTH=4.
- Reset: RST=1 for 2 cycles with arbitrary inputs -> Q=0000, S_OUT=0, BUSY=0, DONE=0.
- Legacy rotate right: load D=0001 (MODO=10), then MODO=01, DIR=1 for 4 clocks -> Q=1000, 0100, 0010, 0001; S_OUT=1, 0, 0, 0.
- Multi-step serial left: Q=1011, START with MODO=00, DIR=0, S_IN=1, AMT=2 -> Q=0111 then 1111; S_OUT=1 then 0; BUSY for 2 cycles; DONE pulses once on the third cycle.
- Arithmetic right: Q=1000, START with MODO=11, DIR=1, AMT=3 -> Q=1100, 1110, 1111; then DONE. A second START on the DONE cycle is accepted.
- ENB pause and ignored START:
  - Stimulus: AMT=4 rotate; ENB=0 for 2 cycles mid-run; START pulsed while BUSY.
  - Response: Q and BUSY hold during the pause; DONE arrives 2 cycles late; the extra START has no effect.
- Reset mid-run: RST after 2 of 4 steps -> next cycle Q=0000, BUSY=0, and no DONE pulse.
